// File: rtl/ps2_keymap_if.sv
// Signal bundle between the PS/2 keyboard receiver and the game input logic.
// The master side is the receiver: it reads the pins and drives the decoded key state.
interface ps2_keymap_if #(
  parameter int unsigned NUM_KEYS = 8
);
  logic                ps2_clk;
  logic                ps2_data;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                code_valid;
  logic [7:0]          code;
  logic                code_ext;
  logic                code_brk;
  logic                frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_down, key_press, key_release, code_valid, code, code_ext, code_brk, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_down, key_press, key_release, code_valid, code, code_ext, code_brk, frame_err
  );
endinterface

// File: rtl/ps2_keymap_rx.sv
// PS/2 keyboard receiver: frame deserialiser with watchdog, E0/F0/E1 prefix handling and
// a table-driven held-key decoder with press/release pulses.
module ps2_keymap_rx #(
  parameter int unsigned           NUM_KEYS    = 8,
  parameter logic [9*NUM_KEYS-1:0] KEYCODES    = {9'h02C, 9'h022, 9'h01A, 9'h029,
                                                  9'h01E, 9'h016, 9'h021, 9'h02D},
  parameter int unsigned           TIMEOUT_CYC = 54000
) (
  input logic         clk,
  input logic         rst,
  ps2_keymap_if.master bus
);
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] TimeoutVal = WdW'(TIMEOUT_CYC);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e              state_q, state_d;
  logic [2:0]          clk_sync_q;   // [0] first stage, [1] synced, [2] previous synced
  logic [1:0]          dat_sync_q;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [8:0]          shift_q, shift_d;
  logic [WdW-1:0]      wdog_q, wdog_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [2:0]          skip_q, skip_d;
  logic [NUM_KEYS-1:0] down_q, down_d, press_q, press_d, release_q, release_d;
  logic                code_valid_q, code_ext_q, code_brk_q, frame_err_q;
  logic [7:0]          code_q;

  logic       fall, din, accept, err, emit;
  logic [7:0] rx_byte;

  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign din     = dat_sync_q[1];
  assign rx_byte = shift_q[7:0];

  // Frame FSM: start bit, 8 data bits LSB first, parity, stop.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wdog_d    = wdog_q;
    accept    = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        wdog_d    = '0;
        bit_cnt_d = '0;
        if (fall && !din) state_d = StRecv;
      end
      StRecv: begin
        if (fall) begin
          wdog_d    = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StIdle;
            if ((^shift_q) && din) accept = 1'b1;
            else                   err    = 1'b1;
          end else begin
            shift_d = {din, shift_q[8:1]};
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_d == TimeoutVal) begin
            state_d = StIdle;
            err     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte decoder and key table update, evaluated in the acceptance cycle.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    skip_d    = skip_q;
    down_d    = down_q;
    press_d   = '0;
    release_d = '0;
    emit      = 1'b0;
    if (err) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (accept) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1: skip_d = 3'd7;
          8'hAA: down_d = '0;
          8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: begin
          end
          default: emit = 1'b1;
        endcase
      end
    end
    if (emit) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if ({ext_q, rx_byte} == KEYCODES[9*i +: 9]) begin
          if (brk_q) begin
            down_d[i]    = 1'b0;
            release_d[i] = down_q[i];
          end else begin
            down_d[i]  = 1'b1;
            press_d[i] = ~down_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= 3'b111;
      dat_sync_q   <= 2'b11;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wdog_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= '0;
      down_q       <= '0;
      press_q      <= '0;
      release_q    <= '0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      code_ext_q   <= 1'b0;
      code_brk_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], bus.ps2_clk};
      dat_sync_q   <= {dat_sync_q[0], bus.ps2_data};
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wdog_q       <= wdog_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      skip_q       <= skip_d;
      down_q       <= down_d;
      press_q      <= press_d;
      release_q    <= release_d;
      code_valid_q <= emit;
      frame_err_q  <= err;
      if (emit) begin
        code_q     <= rx_byte;
        code_ext_q <= ext_q;
        code_brk_q <= brk_q;
      end
    end
  end

  assign bus.key_down    = down_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.code_valid  = code_valid_q;
  assign bus.code        = code_q;
  assign bus.code_ext    = code_ext_q;
  assign bus.code_brk    = code_brk_q;
  assign bus.frame_err   = frame_err_q;
endmodule
